sq_wave_gen: RTL and testbench
==============================

# sq_wave_gen

Programmable square-wave source for the frequency-measurement lab: generates `clk_out` from `CLOCK_50` at a frequency of CLK_HZ / (2 × half-period), for driving the SMA output looped back into the edge counter.
- Start and stop are glitch-free: the output always stops at logic low.
- Frequency changes are applied only on half-period boundaries, so no runt pulses reach the counter under test.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency (documentation and test-plan math only).
- `DIV_W`, 32, width of the half-period value.
- `DEF_HALF`, 25, active half-period after reset (1 MHz at 50 MHz).
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `enable`  in  1  level; 1 = generate, 0 = stop cleanly.
- `load`  in  1  single-cycle strobe; captures `half_period`.
- `half_period`  in  DIV_W  `CLOCK_50` cycles per half-period of `clk_out`.
- `clk_out`  out  1  generated square wave, registered.
- `busy`  out  1  1 while state ≠ IDLE.
- `edge_count`  out  32  rising edges of `clk_out` since reset. Present only with `SQGEN_EDGE_COUNT_EN`.

## Operation
- Registers:
  - `active` (DIV_W): the half-period currently in use.
  - `shadow` (DIV_W) and `pend` (1): a captured value waiting to be applied.
  - `cnt` (DIV_W): down-counter.
  - `state` ∈ {IDLE, RUN}.
- `half_period` = 0 is clamped to 1 when captured. Maximum output frequency is CLK_HZ/2.
- load:
  - In IDLE, `active` ← clamped value directly.
  - In RUN, `shadow` ← clamped value and `pend` ← 1.
  - Several loads before a boundary: the last one wins.
- IDLE:
  - `clk_out` = 0 and `cnt` is held.
  - On `enable` = 1: go to RUN and set `cnt` ← `active` − 1.
- RUN, `cnt` ≠ 0: `cnt` ← `cnt` − 1.
- RUN, `cnt` = 0 (a boundary):
  - If `pend` = 1: `active` ← `shadow`, `pend` ← 0, and the new value is used for this reload.
  - If `clk_out` = 1: `clk_out` ← 0 and `cnt` ← `active` − 1. This is unconditional; the high phase always completes.
  - If `clk_out` = 0 and `enable` = 1: `clk_out` ← 1 and `cnt` reloads.
  - If `clk_out` = 0 and `enable` = 0: go to IDLE, output stays low, and any pending value is committed to `active`.
- If `enable` returns to 1 before the stopping boundary, output continues seamlessly with no phase disturbance.
- `busy` is a registered decode of `state`.

## Timing
- Reset values (asynchronous, immediate):
  - `clk_out` = 0, `busy` = 0, state IDLE.
  - `active` = `DEF_HALF`, `shadow` = 0, `pend` = 0, `cnt` = 0, `edge_count` = 0.
- Start: the edge that samples `enable` = 1 in IDLE sets `busy` = 1. The first rising edge of `clk_out` is registered `active` `CLOCK_50` edges later.
- Steady state: each level of `clk_out` lasts exactly `active` cycles; period is 2·`active`.
- Load in RUN takes effect at the first boundary strictly after the load cycle. A load in the same cycle as a boundary is applied at the following boundary.
- Stop: after `enable` falls, `clk_out` reaches 0 within ≤ `active` cycles. `busy` falls ≤ 2·`active` cycles after that.
- Reset asserted mid-period: `clk_out` drops to 0 asynchronously. That truncated pulse is the only permitted runt.

## Configuration
- `SQGEN_EDGE_COUNT_EN` defined:
  - `edge_count` increments on every registered 0→1 transition of `clk_out`.
  - Wraps modulo 2^32.
  - Not cleared by `enable`; cleared only by reset.
- Undefined: the port and counter are absent and all other behaviour is identical.

## Test plan
- Reset release, `enable` = 1, no load → `clk_out` period 50 cycles (1 MHz); first rise 25 edges after `enable` is sampled; `busy` = 1.
- `load` with `half_period` = 0, then `enable` → clamped to 1; `clk_out` toggles every cycle (25 MHz).
- Running at half-period 25; `load` 5 in the cycle where `cnt` = 0 → current half-period stays 25, the next one is 25 (boundary coincident with load), then 5 from the following boundary; no pulse shorter than 5 cycles.
- `enable` drops 3 cycles into a high phase (half-period 10) → high phase completes (10 cycles total), low follows, `busy` = 0 after that low half-period; `enable` re-raised mid-low → no gap, period stays 20.
- Reset pulse mid-high → `clk_out` = 0 immediately; after release, output is idle at 0 with `active` = 25.
- `SQGEN_EDGE_COUNT_EN`, half-period 25, `enable` held for 50,000 cycles → `edge_count` = 1000.

Source files
------------

// File: rtl/sq_wave_gen_if.sv
// ---------------------------------------------------------------------------
// sq_wave_gen_if
//   Control/status bundle for the programmable square-wave source.
//   master : the controller (drives enable/load/half_period, observes status)
//   slave  : the generator itself
//
//   enable       1 = generate, 0 = stop cleanly at logic low
//   load         single-cycle strobe capturing half_period
//   half_period  CLOCK_50 cycles per half-period of clk_out (0 means 1)
//   clk_out      generated square wave (registered)
//   busy         1 while the generator is not idle
//   edge_count   rising edges of clk_out since reset; present only when the
//                macro SQGEN_EDGE_COUNT_EN is defined
// ---------------------------------------------------------------------------
interface sq_wave_gen_if #(
    parameter int DIV_W = 32
);
    logic             enable;
    logic             load;
    logic [DIV_W-1:0] half_period;
    logic             clk_out;
    logic             busy;
`ifdef SQGEN_EDGE_COUNT_EN
    logic [31:0]      edge_count;

    modport master (output enable, load, half_period, input clk_out, busy, edge_count);
    modport slave  (input enable, load, half_period, output clk_out, busy, edge_count);
`else
    modport master (output enable, load, half_period, input clk_out, busy);
    modport slave  (input enable, load, half_period, output clk_out, busy);
`endif
endinterface

// File: rtl/sq_wave_gen.sv
// ---------------------------------------------------------------------------
// sq_wave_gen
//   Programmable square-wave source. Produces clk_out at
//   CLK_HZ / (2 * half-period) from CLOCK_50. Starting and stopping are
//   glitch-free (the output always parks low) and new half-periods are only
//   applied on half-period boundaries, so no runt pulses are emitted.
//
//   Optional feature macro: SQGEN_EDGE_COUNT_EN
//     defined   -> 32-bit edge_count of registered clk_out rising edges
//     undefined -> counter and port absent, all else identical
//
// Ports
//   CLOCK_50  in   system clock, all logic on its rising edge
//   reset     in   asynchronous active-low reset (0 = reset)
//   bus       slave modport of sq_wave_gen_if:
//               enable, load, half_period  (in)
//               clk_out, busy, edge_count  (out)
// ---------------------------------------------------------------------------
module sq_wave_gen #(
    parameter int unsigned      CLK_HZ   = 50_000_000,
    parameter int               DIV_W    = 32,
    parameter logic [DIV_W-1:0] DEF_HALF = DIV_W'(25)
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    sq_wave_gen_if.slave   bus
);

    // Elaboration-time sanity checks on the configuration.
    if (CLK_HZ < 2) begin : g_clk_hz_check
        $error("sq_wave_gen: CLK_HZ must be at least 2");
    end
    if (DEF_HALF == '0) begin : g_def_half_check
        $error("sq_wave_gen: DEF_HALF must be non-zero");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg,   state_next;
    logic [DIV_W-1:0] active_reg,  active_next;
    logic [DIV_W-1:0] shadow_reg,  shadow_next;
    logic             pend_reg,    pend_next;
    logic [DIV_W-1:0] cnt_reg,     cnt_next;
    logic             clk_out_reg, clk_out_next;
    logic             busy_reg,    busy_next;

    logic [DIV_W-1:0] clamped;
    logic [DIV_W-1:0] reload_half;
    logic             boundary;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            active_reg  <= DEF_HALF;
            shadow_reg  <= '0;
            pend_reg    <= 1'b0;
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            active_reg  <= active_next;
            shadow_reg  <= shadow_next;
            pend_reg    <= pend_next;
            cnt_reg     <= cnt_next;
            clk_out_reg <= clk_out_next;
            busy_reg    <= busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        active_next  = active_reg;
        shadow_next  = shadow_reg;
        pend_next    = pend_reg;
        cnt_next     = cnt_reg;
        clk_out_next = clk_out_reg;

        // A zero half-period would stall the counter; treat it as 1.
        clamped     = (bus.half_period == '0) ? DIV_W'(1) : bus.half_period;
        boundary    = (cnt_reg == '0);
        // A pending value is committed at the boundary and used for this
        // very reload, so the reload must see it before active updates.
        reload_half = pend_reg ? shadow_reg : active_reg;

        case (state_reg)
            IDLE: begin
                clk_out_next = 1'b0;
                if (bus.load) begin
                    active_next = clamped;
                end
                if (bus.enable) begin
                    state_next = RUN;
                    // A load coinciding with the start is honoured at once.
                    cnt_next   = (bus.load ? clamped : active_reg) - DIV_W'(1);
                end
            end

            RUN: begin
                if (!boundary) begin
                    cnt_next = cnt_reg - DIV_W'(1);
                end else begin
                    if (pend_reg) begin
                        active_next = shadow_reg;
                        pend_next   = 1'b0;
                    end
                    if (clk_out_reg) begin
                        // The high phase always completes, enable or not.
                        clk_out_next = 1'b0;
                        cnt_next     = reload_half - DIV_W'(1);
                    end else if (bus.enable) begin
                        clk_out_next = 1'b1;
                        cnt_next     = reload_half - DIV_W'(1);
                    end else begin
                        // Stop at the end of a low phase; cnt stays at zero.
                        state_next = IDLE;
                    end
                end

                // Loads while running wait in the shadow until the first
                // boundary strictly after the load cycle. If this edge is the
                // one that parks the generator, write active directly instead
                // so the value is not stranded in the shadow.
                if (bus.load) begin
                    if (boundary && !clk_out_reg && !bus.enable) begin
                        active_next = clamped;
                        pend_next   = 1'b0;
                    end else begin
                        shadow_next = clamped;
                        pend_next   = 1'b1;
                    end
                end
            end

            default: begin
                state_next   = IDLE;
                clk_out_next = 1'b0;
            end
        endcase

        busy_next = (state_next == RUN);
    end

    assign bus.clk_out = clk_out_reg;
    assign bus.busy    = busy_reg;

`ifdef SQGEN_EDGE_COUNT_EN
    // Counts registered 0->1 transitions; wraps modulo 2^32 and is only
    // cleared by reset.
    logic [31:0] edge_count_reg;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            edge_count_reg <= '0;
        end else if (clk_out_next && !clk_out_reg) begin
            edge_count_reg <= edge_count_reg + 32'd1;
        end
    end

    assign bus.edge_count = edge_count_reg;
`endif

endmodule

// File: tb/tb_sq_wave_gen.sv
// ---------------------------------------------------------------------------
// tb_sq_wave_gen
//   Directed bench for sq_wave_gen. The stimulus process pushes the expected
//   output changes (edge index, clk_out, busy) into a queue; the monitor
//   process watches clk_out/busy on every falling clock edge and, whenever
//   either changes, pops and compares the next expected change.
//   The edge_count scenario is compiled in only with SQGEN_EDGE_COUNT_EN.
// ---------------------------------------------------------------------------
module tb_sq_wave_gen;

    logic CLOCK_50;
    logic reset;

    sq_wave_gen_if #(.DIV_W(32)) bus ();

    sq_wave_gen #(
        .CLK_HZ   (50_000_000),
        .DIV_W    (32),
        .DEF_HALF (32'd25)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Number of rising clock edges seen so far.
    int unsigned edge_n = 0;
    always @(posedge CLOCK_50) edge_n <= edge_n + 1;

    typedef struct {
        int unsigned at;
        logic        clk;
        logic        busy;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic expect_ev(input int unsigned at, input logic c, input logic b);
        ev_t e;
        e.at   = at;
        e.clk  = c;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Wait (on falling edges) until at least n rising edges have happened.
    task automatic tick_to(input int unsigned n);
        while (edge_n < n) @(negedge CLOCK_50);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic prev_clk  = 1'b0;
    logic prev_busy = 1'b0;
    ev_t  mon_e;

    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (bus.clk_out !== prev_clk || bus.busy !== prev_busy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: edge %0d clk_out=%b busy=%b, nothing expected",
                             edge_n, bus.clk_out, bus.busy);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.at != edge_n || mon_e.clk !== bus.clk_out || mon_e.busy !== bus.busy) begin
                        errors++;
                        $display("FAIL wave_change: got edge %0d clk_out=%b busy=%b, expected edge %0d clk_out=%b busy=%b",
                                 edge_n, bus.clk_out, bus.busy, mon_e.at, mon_e.clk, mon_e.busy);
                    end else begin
                        $display("ok   wave_change: edge %0d clk_out=%b busy=%b",
                                 edge_n, bus.clk_out, bus.busy);
                    end
                end
                prev_clk  = bus.clk_out;
                prev_busy = bus.busy;
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, edge %0d", edge_n);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int unsigned s;

    initial begin
        bus.enable      = 1'b0;
        bus.load        = 1'b0;
        bus.half_period = '0;
        reset           = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        // Reset state
        check_val("reset_clk_out", {31'd0, bus.clk_out}, 32'd0);
        check_val("reset_busy",    {31'd0, bus.busy},    32'd0);
`ifdef SQGEN_EDGE_COUNT_EN
        check_val("reset_edge_count", bus.edge_count, 32'd0);
`endif
        #2 reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // 1) Default half-period 25: first rise 25 edges after start, period 50.
        s = edge_n + 1;
        expect_ev(s,       1'b0, 1'b1);
        expect_ev(s + 25,  1'b1, 1'b1);
        expect_ev(s + 50,  1'b0, 1'b1);
        expect_ev(s + 75,  1'b1, 1'b1);
        expect_ev(s + 100, 1'b0, 1'b1);
        expect_ev(s + 125, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick_to(s + 101);
        bus.enable = 1'b0;
        tick_to(s + 127);

        // 2) Load 0 in IDLE -> clamped to 1, clk_out toggles every cycle.
        bus.load        = 1'b1;
        bus.half_period = 32'd0;
        @(negedge CLOCK_50);
        bus.load = 1'b0;
        s = edge_n + 1;
        expect_ev(s, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) expect_ev(s + k, k[0], 1'b1);
        expect_ev(s + 9, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick_to(s + 8);
        bus.enable = 1'b0;
        tick_to(s + 11);

        // Back to 25 while idle.
        bus.load        = 1'b1;
        bus.half_period = 32'd25;
        @(negedge CLOCK_50);
        bus.load = 1'b0;

        // 3) Load 5 coincident with a boundary: 25, 25, then 5.
        //    Then load 10 mid-phase, and drop enable 3 cycles into a high phase.
        s = edge_n + 1;
        expect_ev(s,       1'b0, 1'b1);
        expect_ev(s + 25,  1'b1, 1'b1);
        expect_ev(s + 50,  1'b0, 1'b1);
        expect_ev(s + 75,  1'b1, 1'b1);
        expect_ev(s + 80,  1'b0, 1'b1);
        expect_ev(s + 85,  1'b1, 1'b1);
        expect_ev(s + 90,  1'b0, 1'b1);
        expect_ev(s + 95,  1'b1, 1'b1);
        expect_ev(s + 105, 1'b0, 1'b1);
        expect_ev(s + 115, 1'b1, 1'b1);
        expect_ev(s + 125, 1'b0, 1'b1);
        expect_ev(s + 135, 1'b1, 1'b1);
        expect_ev(s + 145, 1'b0, 1'b1);
        expect_ev(s + 155, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick_to(s + 49);
        bus.load        = 1'b1;
        bus.half_period = 32'd5;
        tick_to(s + 50);
        bus.load = 1'b0;
        tick_to(s + 91);
        bus.load        = 1'b1;
        bus.half_period = 32'd10;
        tick_to(s + 92);
        bus.load = 1'b0;
        tick_to(s + 137);
        bus.enable = 1'b0;
        tick_to(s + 158);

        // 4) Half-period 10: enable drops in high, returns mid-low -> no gap.
        //    Then an asynchronous reset in the middle of a high phase.
        s = edge_n + 1;
        expect_ev(s,      1'b0, 1'b1);
        expect_ev(s + 10, 1'b1, 1'b1);
        expect_ev(s + 20, 1'b0, 1'b1);
        expect_ev(s + 30, 1'b1, 1'b1);
        expect_ev(s + 40, 1'b0, 1'b1);
        expect_ev(s + 50, 1'b1, 1'b1);
        expect_ev(s + 54, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick_to(s + 12);
        bus.enable = 1'b0;
        tick_to(s + 24);
        bus.enable = 1'b1;
        tick_to(s + 53);
        #2 reset = 1'b0;
        #1;
        check_val("async_reset_clk_out", {31'd0, bus.clk_out}, 32'd0);
        check_val("async_reset_busy",    {31'd0, bus.busy},    32'd0);
        bus.enable = 1'b0;
        tick_to(s + 56);
        #2 reset = 1'b1;
        tick_to(s + 58);

        // 5) After reset the active half-period is back to 25.
        s = edge_n + 1;
        expect_ev(s,      1'b0, 1'b1);
        expect_ev(s + 25, 1'b1, 1'b1);
        expect_ev(s + 50, 1'b0, 1'b1);
        expect_ev(s + 75, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick_to(s + 25);
        bus.enable = 1'b0;
        tick_to(s + 78);

`ifdef SQGEN_EDGE_COUNT_EN
        // 6) Edge counter: 50,000 cycles at half-period 25 -> 1000 rises.
        #2 reset = 1'b0;
        #1;
        check_val("edge_count_after_reset", bus.edge_count, 32'd0);
        @(negedge CLOCK_50);
        #2 reset = 1'b1;
        @(negedge CLOCK_50);
        s = edge_n + 1;
        expect_ev(s, 1'b0, 1'b1);
        for (int k = 0; k < 1000; k++) begin
            expect_ev(s + 25 + 50 * k, 1'b1, 1'b1);
            expect_ev(s + 50 + 50 * k, 1'b0, 1'b1);
        end
        expect_ev(s + 50025, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick_to(s + 49999);
        check_val("edge_count_50000_cycles", bus.edge_count, 32'd1000);
        bus.enable = 1'b0;
        tick_to(s + 50028);
        check_val("edge_count_after_stop", bus.edge_count, 32'd1000);
`endif

        // Drain: any expected change that never appeared is a failure.
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge CLOCK_50);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_change: never observed, expected edge %0d clk_out=%b busy=%b",
                     e.at, e.clk, e.busy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
